// File: rtl/rr_four_core_dispatch_pkg.sv
// rr_dispatch_pkg: shared types and helpers for the four-core job dispatcher.
//   core_state_e : per-core lifecycle (IDLE -> BUSY -> HOLD -> IDLE)
//   res_entry_t  : one queued result {data, tag, seq}
//   rr_pick      : round-robin search, first set bit at or after ptr (mod N_CORES)
`timescale 1ns/1ps
package rr_dispatch_pkg;

    localparam int N_CORES    = 4;
    localparam int TAG_W      = 2;
    localparam int RES_DATA_W = 32;
    localparam int RES_SEQ_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        HOLD
    } core_state_e;

    typedef struct packed {
        logic [RES_DATA_W-1:0] data;
        logic [TAG_W-1:0]      tag;
        logic [RES_SEQ_W-1:0]  seq;
    } res_entry_t;

    // Returns ptr unchanged when mask is empty; callers gate on |mask.
    function automatic logic [TAG_W-1:0] rr_pick(input logic [N_CORES-1:0] mask,
                                                 input logic [TAG_W-1:0]   ptr);
        logic [TAG_W-1:0] idx;
        logic [TAG_W-1:0] pick;
        logic             found;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned i = 0; i < N_CORES; i++) begin
            idx = ptr + TAG_W'(i);
            if (!found && mask[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_four_core_dispatch_if.sv
// rr_four_core_dispatch_if: job intake and result drain handshakes.
//   s_job_valid/s_job_ready/s_job_data : job stream into the dispatcher
//   m_res_valid/m_res_ready/m_res_data/m_res_tag/m_res_seq : result FIFO head
// Modports: master = register-bank side, slave = dispatcher side.
`timescale 1ns/1ps
interface rr_four_core_dispatch_if #(
    parameter int DATA_W = 32,
    parameter int SEQ_W  = 8
) ();
    logic              s_job_valid;
    logic              s_job_ready;
    logic [DATA_W-1:0] s_job_data;
    logic              m_res_valid;
    logic              m_res_ready;
    logic [DATA_W-1:0] m_res_data;
    logic [1:0]        m_res_tag;
    logic [SEQ_W-1:0]  m_res_seq;

    modport master (
        output s_job_valid, s_job_data, m_res_ready,
        input  s_job_ready, m_res_valid, m_res_data, m_res_tag, m_res_seq
    );

    modport slave (
        input  s_job_valid, s_job_data, m_res_ready,
        output s_job_ready, m_res_valid, m_res_data, m_res_tag, m_res_seq
    );
endinterface

// File: rtl/rr_four_core_dispatch_res_fifo.sv
// rr_res_fifo: first-word-fall-through FIFO of res_entry_t.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and entry (accepted when not full or popping)
//   pop, dout  : pop request (ignored when empty) and head entry (zero when empty)
//   count, full, empty : occupancy status
`timescale 1ns/1ps
module rr_res_fifo
    import rr_dispatch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  res_entry_t                 din,
    input  logic                       pop,
    output res_entry_t                 dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);

    res_entry_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign rd_en = pop && !empty;
    // When full, a same-cycle pop frees the slot being written.
    assign wr_en = push && (!full || rd_en);

    always_comb begin
        dout = '0;
        if (!empty) dout = mem[rd_ptr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/rr_four_core_dispatch.sv
// rr_four_core_dispatch: round-robin job dispatcher for four cipher cores with
// an ordered, tagged result FIFO.
//   ACLK, ARESETN : clock, asynchronous active-low reset
//   bus (slave)   : job intake handshake and result FIFO head
//   core_start    : one-cycle start pulse per core
//   core_din      : registered job payload, valid with core_start
//   core_done     : one-cycle completion pulse per core
//   core_dout     : core k result at [k*DATA_W +: DATA_W]
//   busy_mask     : core k not IDLE
//   err_spurious  : sticky, core_done seen for a core that was not BUSY
// Optional macro DISPATCH_PERF_CNT_EN adds perf_jobs / perf_stall saturating counters.
`timescale 1ns/1ps
module rr_four_core_dispatch #(
    parameter int DATA_W     = 32,
    parameter int N_CORES    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int SEQ_W      = 8
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    rr_four_core_dispatch_if.slave    bus,
    output logic [N_CORES-1:0]        core_start,
    output logic [DATA_W-1:0]         core_din,
    input  logic [N_CORES-1:0]        core_done,
    input  logic [N_CORES*DATA_W-1:0] core_dout,
    output logic [N_CORES-1:0]        busy_mask,
    output logic                      err_spurious
`ifdef DISPATCH_PERF_CNT_EN
    ,
    output logic [31:0]               perf_jobs,
    output logic [31:0]               perf_stall
`endif
);
    import rr_dispatch_pkg::*;

    core_state_e      state_q [N_CORES];
    core_state_e      state_d [N_CORES];
    logic [SEQ_W-1:0] seq_q;
    logic [SEQ_W-1:0] core_seq  [N_CORES];
    logic [DATA_W-1:0] hold_data [N_CORES];
    logic [SEQ_W-1:0] hold_seq  [N_CORES];

    logic [TAG_W-1:0]   rr_ptr;
    logic [TAG_W-1:0]   drain_ptr;
    logic [TAG_W-1:0]   disp_idx;
    logic [TAG_W-1:0]   drain_idx;
    logic [N_CORES-1:0] idle_mask;
    logic [N_CORES-1:0] bsy_mask;
    logic [N_CORES-1:0] hold_mask;
    logic               accept;
    logic               push;
    logic               pop;

    res_entry_t               push_entry;
    res_entry_t               head;
    logic [$clog2(FIFO_DEPTH):0] unused_fifo_count;
    logic                     fifo_full;
    logic                     fifo_empty;

    // Per-core FSM: state register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int unsigned k = 0; k < N_CORES; k++) state_q[k] <= IDLE;
        end else begin
            for (int unsigned k = 0; k < N_CORES; k++) state_q[k] <= state_d[k];
        end
    end

    // Per-core FSM: next state. Dispatch only targets IDLE and drain only
    // targets HOLD, so the two never touch the same core in one cycle.
    always_comb begin
        for (int unsigned k = 0; k < N_CORES; k++) begin
            state_d[k] = state_q[k];
            case (state_q[k])
                IDLE: if (accept && disp_idx == TAG_W'(k)) state_d[k] = BUSY;
                BUSY: if (core_done[k])                    state_d[k] = HOLD;
                HOLD: if (push && drain_idx == TAG_W'(k))  state_d[k] = IDLE;
                default:                                   state_d[k] = IDLE;
            endcase
        end
    end

    // Per-core FSM: decoded outputs.
    always_comb begin
        idle_mask = '0;
        bsy_mask  = '0;
        hold_mask = '0;
        for (int unsigned k = 0; k < N_CORES; k++) begin
            idle_mask[k] = (state_q[k] == IDLE);
            bsy_mask[k]  = (state_q[k] == BUSY);
            hold_mask[k] = (state_q[k] == HOLD);
        end
    end

    assign busy_mask       = ~idle_mask;
    assign bus.s_job_ready = ARESETN && (|idle_mask);
    assign accept          = bus.s_job_valid && bus.s_job_ready;
    assign disp_idx        = rr_pick(idle_mask, rr_ptr);
    assign drain_idx       = rr_pick(hold_mask, drain_ptr);
    assign pop             = bus.m_res_ready && !fifo_empty;
    assign push            = (|hold_mask) && (!fifo_full || pop);

    always_comb begin
        push_entry      = '0;
        push_entry.data = hold_data[drain_idx];
        push_entry.tag  = drain_idx;
        push_entry.seq  = hold_seq[drain_idx];
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            seq_q        <= '0;
            rr_ptr       <= '0;
            drain_ptr    <= '0;
            core_start   <= '0;
            core_din     <= '0;
            err_spurious <= 1'b0;
            for (int unsigned k = 0; k < N_CORES; k++) begin
                core_seq[k]  <= '0;
                hold_data[k] <= '0;
                hold_seq[k]  <= '0;
            end
        end else begin
            core_start <= '0;
            if (accept) begin
                core_start         <= N_CORES'(1) << disp_idx;
                core_din           <= bus.s_job_data;
                core_seq[disp_idx] <= seq_q;
                seq_q              <= seq_q + 1'b1;
                rr_ptr             <= disp_idx + 1'b1;
            end
            for (int unsigned k = 0; k < N_CORES; k++) begin
                if (core_done[k] && bsy_mask[k]) begin
                    hold_data[k] <= core_dout[k*DATA_W +: DATA_W];
                    hold_seq[k]  <= core_seq[k];
                end
            end
            if (push) drain_ptr <= drain_idx + 1'b1;
            if (|(core_done & ~bsy_mask)) err_spurious <= 1'b1;
        end
    end

`ifdef DISPATCH_PERF_CNT_EN
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            perf_jobs  <= '0;
            perf_stall <= '0;
        end else begin
            if (accept && perf_jobs != '1) perf_jobs <= perf_jobs + 1'b1;
            if (bus.s_job_valid && !bus.s_job_ready && perf_stall != '1)
                perf_stall <= perf_stall + 1'b1;
        end
    end
`endif

    rr_res_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_res_fifo (
        .clk   (ACLK),
        .rst_n (ARESETN),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head),
        .count (unused_fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.m_res_valid = !fifo_empty;
    assign bus.m_res_data  = head.data;
    assign bus.m_res_tag   = head.tag;
    assign bus.m_res_seq   = head.seq;
endmodule

// File: tb/tb_rr_four_core_dispatch.sv
// tb_rr_four_core_dispatch: directed self-checking bench for rr_four_core_dispatch.
`timescale 1ns/1ps
module tb_rr_four_core_dispatch;

    logic          ACLK;
    logic          ARESETN;
    logic [3:0]    core_start;
    logic [31:0]   core_din;
    logic [3:0]    core_done;
    logic [127:0]  core_dout;
    logic [3:0]    busy_mask;
    logic          err_spurious;

    int total = 0;
    int bad   = 0;

    rr_four_core_dispatch_if #(.DATA_W(32), .SEQ_W(8)) bus ();

    rr_four_core_dispatch #(
        .DATA_W     (32),
        .N_CORES    (4),
        .FIFO_DEPTH (4),
        .SEQ_W      (8)
    ) dut (
        .ACLK         (ACLK),
        .ARESETN      (ARESETN),
        .bus          (bus),
        .core_start   (core_start),
        .core_din     (core_din),
        .core_done    (core_done),
        .core_dout    (core_dout),
        .busy_mask    (busy_mask),
        .err_spurious (err_spurious)
`ifdef DISPATCH_PERF_CNT_EN
        ,
        .perf_jobs    (),
        .perf_stall   ()
`endif
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offers one job, waits (bounded) for ready, returns in the cycle after acceptance.
    task automatic send_job(input logic [31:0] data);
        bus.s_job_valid = 1'b1;
        bus.s_job_data  = data;
        for (int n = 0; n < 50 && !bus.s_job_ready; n++) step();
        check("job_ready", {63'd0, bus.s_job_ready}, 64'd1);
        step();
        bus.s_job_valid = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [31:0] data,
                             input logic [1:0] rtag, input logic [7:0] seq);
        for (int n = 0; n < 50 && !bus.m_res_valid; n++) step();
        check({tag, "_valid"}, {63'd0, bus.m_res_valid}, 64'd1);
        check({tag, "_data"},  {32'd0, bus.m_res_data}, {32'd0, data});
        check({tag, "_tag"},   {62'd0, bus.m_res_tag},  {62'd0, rtag});
        check({tag, "_seq"},   {56'd0, bus.m_res_seq},  {56'd0, seq});
        bus.m_res_ready = 1'b1;
        step();
        bus.m_res_ready = 1'b0;
    endtask

    task automatic finish_core(input int k, input logic [31:0] dout);
        core_dout[k*32 +: 32] = dout;
        core_done             = 4'b0001 << k;
        step();
        core_done             = 4'b0000;
    endtask

    initial begin
        logic [3:0] exp_start;
        int         k;

        ARESETN         = 1'b0;
        bus.s_job_valid = 1'b0;
        bus.s_job_data  = '0;
        bus.m_res_ready = 1'b0;
        core_done       = '0;
        core_dout       = '0;
        step();
        step();

        // Reset state
        check("rst_ready",  {63'd0, bus.s_job_ready}, 64'd0);
        check("rst_busy",   {60'd0, busy_mask}, 64'd0);
        check("rst_valid",  {63'd0, bus.m_res_valid}, 64'd0);
        check("rst_start",  {60'd0, core_start}, 64'd0);
        check("rst_din",    {32'd0, core_din}, 64'd0);
        check("rst_data",   {32'd0, bus.m_res_data}, 64'd0);
        check("rst_tag",    {62'd0, bus.m_res_tag}, 64'd0);
        check("rst_seq",    {56'd0, bus.m_res_seq}, 64'd0);
        check("rst_err",    {63'd0, err_spurious}, 64'd0);
        ARESETN = 1'b1;
        step();

        // 1: four back-to-back jobs fill cores 0..3, fifth is stalled
        bus.s_job_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.s_job_data = 32'(i + 1);
            step();
            exp_start = 4'b0001 << i;
            check("t1_start", {60'd0, core_start}, {60'd0, exp_start});
            check("t1_din",   {32'd0, core_din}, 64'(i + 1));
        end
        bus.s_job_data = 32'h5;
        check("t1_ready_full", {63'd0, bus.s_job_ready}, 64'd0);
        check("t1_busy",       {60'd0, busy_mask}, 64'hF);
        step();
        check("t1_no_start",   {60'd0, core_start}, 64'd0);
        bus.s_job_valid = 1'b0;

        // 2: cores 2 and 0 complete together; drained in round-robin order
        core_dout[0*32 +: 32] = 32'hBB;
        core_dout[2*32 +: 32] = 32'hAA;
        core_done             = 4'b0101;
        bus.m_res_ready       = 1'b1;
        step();
        core_done = 4'b0000;
        check("t2_valid_hold", {63'd0, bus.m_res_valid}, 64'd0);
        check("t2_busy_hold",  {60'd0, busy_mask}, 64'hF);
        step();
        check("t2_valid1", {63'd0, bus.m_res_valid}, 64'd1);
        check("t2_data1",  {32'd0, bus.m_res_data}, 64'hBB);
        check("t2_tag1",   {62'd0, bus.m_res_tag}, 64'd0);
        check("t2_seq1",   {56'd0, bus.m_res_seq}, 64'd0);
        check("t2_busy1",  {60'd0, busy_mask}, 64'hE);
        step();
        check("t2_data2",  {32'd0, bus.m_res_data}, 64'hAA);
        check("t2_tag2",   {62'd0, bus.m_res_tag}, 64'd2);
        check("t2_seq2",   {56'd0, bus.m_res_seq}, 64'd2);
        check("t2_busy2",  {60'd0, busy_mask}, 64'hA);
        step();
        check("t2_empty",  {63'd0, bus.m_res_valid}, 64'd0);
        bus.m_res_ready = 1'b0;

        // 3: FIFO fills, then held results backpressure new jobs
        send_job(32'h10);
        check("t3_start_a", {60'd0, core_start}, 64'h1);
        send_job(32'h11);
        check("t3_start_b", {60'd0, core_start}, 64'h4);
        for (int i = 0; i < 4; i++) core_dout[i*32 +: 32] = 32'h100 + 32'(i);
        core_done = 4'b1111;
        step();
        core_done = 4'b0000;
        for (int i = 0; i < 4; i++) step();
        check("t3_busy_idle", {60'd0, busy_mask}, 64'd0);
        check("t3_head_data", {32'd0, bus.m_res_data}, 64'h103);
        check("t3_head_tag",  {62'd0, bus.m_res_tag}, 64'd3);
        send_job(32'h20);
        check("t3_start_c", {60'd0, core_start}, 64'h8);
        send_job(32'h21);
        send_job(32'h22);
        send_job(32'h23);
        check("t3_start_f", {60'd0, core_start}, 64'h4);
        for (int i = 0; i < 4; i++) core_dout[i*32 +: 32] = 32'h200 + 32'(i);
        core_done = 4'b1111;
        step();
        core_done = 4'b0000;
        step();
        step();
        check("t3_busy_full",  {60'd0, busy_mask}, 64'hF);
        bus.s_job_valid = 1'b1;
        bus.s_job_data  = 32'h30;
        check("t3_ready_stall", {63'd0, bus.s_job_ready}, 64'd0);
        step();
        check("t3_stall_start", {60'd0, core_start}, 64'd0);
        check("t3_head_kept",   {32'd0, bus.m_res_data}, 64'h103);
        bus.m_res_ready = 1'b1;
        step();
        bus.m_res_ready = 1'b0;
        check("t3_ready_freed", {63'd0, bus.s_job_ready}, 64'd1);
        check("t3_head_next",   {32'd0, bus.m_res_data}, 64'h100);
        step();
        bus.s_job_valid = 1'b0;
        check("t3_start_g", {60'd0, core_start}, 64'h8);
        check("t3_din_g",   {32'd0, core_din}, 64'h30);
        pop_check("t3_r1", 32'h100, 2'd0, 8'd4);
        pop_check("t3_r2", 32'h101, 2'd1, 8'd1);
        pop_check("t3_r3", 32'h102, 2'd2, 8'd5);
        pop_check("t3_r4", 32'h203, 2'd3, 8'd6);
        pop_check("t3_r5", 32'h200, 2'd0, 8'd7);
        pop_check("t3_r6", 32'h201, 2'd1, 8'd8);
        pop_check("t3_r7", 32'h202, 2'd2, 8'd9);
        finish_core(3, 32'h303);
        pop_check("t3_r8", 32'h303, 2'd3, 8'd10);

        // 4: done on an idle core is flagged and leaves the FIFO untouched
        check("t4_err_before", {63'd0, err_spurious}, 64'd0);
        finish_core(1, 32'hDEAD);
        step();
        check("t4_err",      {63'd0, err_spurious}, 64'd1);
        check("t4_no_valid", {63'd0, bus.m_res_valid}, 64'd0);
        check("t4_busy",     {60'd0, busy_mask}, 64'd0);
        step();
        step();
        check("t4_err_sticky", {63'd0, err_spurious}, 64'd1);

        // 5: 260 jobs, each completed at once; seq wraps, tags rotate
        for (int i = 0; i < 260; i++) begin
            k = i % 4;
            send_job(32'h0100_0000 + 32'(i));
            exp_start = 4'b0001 << k;
            check("t5_start", {60'd0, core_start}, {60'd0, exp_start});
            finish_core(k, 32'hC000_0000 | 32'(i));
            pop_check("t5_res", 32'hC000_0000 | 32'(i), 2'(k), 8'((11 + i) % 256));
        end

        // 6: reset with two busy cores and one queued result
        send_job(32'hA0);
        send_job(32'hA1);
        send_job(32'hA2);
        finish_core(2, 32'hEE);
        step();
        check("t6_queued", {63'd0, bus.m_res_valid}, 64'd1);
        check("t6_busy",   {60'd0, busy_mask}, 64'h3);
        ARESETN = 1'b0;
        #1;
        check("t6_rst_busy",  {60'd0, busy_mask}, 64'd0);
        check("t6_rst_valid", {63'd0, bus.m_res_valid}, 64'd0);
        check("t6_rst_err",   {63'd0, err_spurious}, 64'd0);
        check("t6_rst_ready", {63'd0, bus.s_job_ready}, 64'd0);
        bus.s_job_valid = 1'b1;
        step();
        check("t6_rst_start", {60'd0, core_start}, 64'd0);
        step();
        bus.s_job_valid = 1'b0;
        ARESETN = 1'b1;
        step();
        send_job(32'h77);
        check("t6_start", {60'd0, core_start}, 64'h1);
        check("t6_din",   {32'd0, core_din}, 64'h77);
        finish_core(0, 32'h1234);
        pop_check("t6_res", 32'h1234, 2'd0, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_four_core_dispatch.md
Name: rr_four_core_dispatch

Overview:
Job dispatcher between the AXI4-Lite register bank and the four reduced-round cipher cores. It accepts 32-bit jobs over a valid/ready handshake and starts them round-robin on idle cores. Each core's result is captured and queued in an ordered result FIFO with a core tag and sequence number. The register bank drains that FIFO for readback.

Parameters:
DATA_W, 32, job/result data width (matches S00_AXI data width)
N_CORES, 4, number of cores; fixed at 4 (TAG_W = 2)
FIFO_DEPTH, 4, result FIFO entries, power of two >= 2
SEQ_W, 8, job sequence number width, wraps modulo 2^SEQ_W

Ports:
ACLK  in  1  clock; all logic rising-edge
ARESETN  in  1  asynchronous, active-low reset
s_job_valid  in  1  job offered
s_job_ready  out  1  job accepted when valid&ready
s_job_data  in  DATA_W  job payload
core_start  out  N_CORES  one-cycle start pulse per core
core_din  out  DATA_W  registered payload, valid while core_start pulses
core_done  in  N_CORES  one-cycle completion pulse per core
core_dout  in  N_CORES*DATA_W  core k result at [k*DATA_W +: DATA_W], valid with core_done[k]
m_res_valid  out  1  FIFO head valid
m_res_ready  in  1  consumer pop
m_res_data  out  DATA_W  head result
m_res_tag  out  2  core index that produced head
m_res_seq  out  SEQ_W  sequence number of the job
busy_mask  out  N_CORES  core k not IDLE
err_spurious  out  1  sticky; core_done[k] while core k not BUSY

Behaviour:
- Reset (async assert, sync release): all cores IDLE; rr_ptr=0; seq=0; FIFO empty. Outputs: core_start=0, core_din=0, m_res_valid=0, m_res_data/tag/seq=0, busy_mask=0, err_spurious=0, s_job_ready=0 while ARESETN low.
- Per-core FSM: IDLE -> BUSY on dispatch; BUSY -> HOLD on core_done[k]; result latched into hold_k with tag k and the job's seq; HOLD -> IDLE the cycle after hold_k is written into the FIFO.
- s_job_ready is combinational: 1 iff at least one core is IDLE.
- Dispatch target: first IDLE core at or after rr_ptr, searching upward modulo 4. On accept at edge t:
  - core_start[k]=1 and core_din=s_job_data during cycle t+1 only.
  - The core's seq_k is set to seq; seq increments and wraps.
  - rr_ptr becomes k+1 mod 4.
- Drain arbiter: each cycle, if the FIFO is not full (or a pop occurs the same cycle), one HOLD core is written to the FIFO. The core is chosen round-robin by a separate drain pointer, lowest index at or after that pointer.
  - Latency: core_done at edge t -> HOLD at t+1 -> FIFO write at t+2 -> m_res_valid at t+2 if the FIFO was empty. The core is IDLE from t+2 and can be re-dispatched at t+2.
- FIFO is first-word-fall-through. Simultaneous push and pop when full is allowed. Push is blocked when full and no pop: cores stay in HOLD, giving backpressure with no loss.
- Pop with m_res_valid=0 is ignored.
- Multiple core_done in one cycle: all are latched into their hold registers; draining serialises them one per cycle.
- core_done[k] for a core in IDLE or HOLD sets err_spurious and is otherwise ignored; a HOLD result is never overwritten. err_spurious clears only on reset.
- Mid-operation reset: in-flight jobs and queued results are discarded; no core_start is emitted during reset.

Optional Feature:
DISPATCH_PERF_CNT_EN: adds output ports perf_jobs (32b, count of accepted jobs) and perf_stall (32b, cycles with s_job_valid=1 and s_job_ready=0). Both are saturating and reset to 0. Without the macro these ports and counters do not exist.

Decomposition:
- Package rr_dispatch_pkg holds:
  - core_state_e {IDLE, BUSY, HOLD}
  - res_entry_t struct {data, tag, seq}
  - constants N_CORES=4, TAG_W=2
  - function rr_pick(mask, ptr) returning the first set index at or after ptr
- Sub-module rr_res_fifo: parameterised FWFT FIFO of res_entry_t, with count, full and empty.

Test Plan:
1. Reset, then offer jobs 0x1..0x4 back-to-back -> core_start pulses 0001, 0010, 0100, 1000 on consecutive cycles, core_din 0x1..0x4 respectively, seq 0..3; s_job_ready=0 on the fifth job.
2. core_done on cores 2 and 0 in the same cycle with dout 0xAA, 0xBB, m_res_ready=1 -> FIFO outputs (0xBB, tag 0, seq 0) then (0xAA, tag 2, seq 2); first m_res_valid 2 cycles after done.
3. m_res_ready=0, complete all 4 cores with FIFO_DEPTH=4 -> FIFO full; offer fifth job -> ready only after a pop frees a core; no result lost, order preserved.
4. core_done[1] pulse while core 1 IDLE -> err_spurious=1 and stays high; FIFO unchanged.
5. Dispatch 260 jobs, each completed immediately -> m_res_seq wraps 255 -> 0; tags cycle 0,1,2,3.
6. Deassert ARESETN with 2 BUSY cores and 1 queued result -> busy_mask=0, m_res_valid=0, err_spurious=0 immediately; after release, first new job goes to core 0 with seq 0.
